mem_port_master: RTL and testbench
==================================

MEM_PORT_MASTER -- requirements
Module: mem_port_master

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 28, storage row address width.
REQ-002 SHALL have parameter ROW_WIDTH, default 32, storage row data width.
REQ-003 SHALL have parameter WAIT_LIMIT, default 15, read-grant stall cycles before starvation flag; 4-bit counter, legal values 1..15.
REQ-004 SHALL have one clock and one reset: clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 reqValid  in  1  client request present.
REQ-007 reqReady  out  1  master accepts request this cycle.
REQ-008 reqWrite  in  1  1 = write request, 0 = read request.
REQ-009 reqAddr  in  ADDR_SIZE  request row address.
REQ-010 reqWdata  in  ROW_WIDTH  write data.
REQ-011 respValid  out  1  response available.
REQ-012 respReady  in  1  client consumes response.
REQ-013 respData  out  ROW_WIDTH  read data, or echo of write data.
REQ-014 memReadAddr  out  ADDR_SIZE  storage read address, driven from latched request.
REQ-015 memReadEn  out  1  storage read enable.
REQ-016 memReadFin  in  1  storage read grant; memReadData valid this cycle.
REQ-017 memReadData  in  ROW_WIDTH  storage combinational read data.
REQ-018 memWriteAddr  out  ADDR_SIZE; memWriteData  out  ROW_WIDTH; memWriteEn  out  1  storage write port.
REQ-019 starveErr  out  1  sticky: a read waited WAIT_LIMIT cycles without grant.

Function
REQ-020 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-021 reqReady SHALL be 1 exactly when state is IDLE.
REQ-022 In IDLE, when reqValid=1: latch reqAddr, reqWdata, reqWrite; next state WRITE if reqWrite=1, else READ; wait counter cleared to 0.
REQ-023 In READ: memReadEn=1 and memReadAddr=latched address, both held stable until grant.
REQ-024 In READ with memReadFin=1: register memReadData into respData at that edge; next state RESP.
REQ-025 In READ with memReadFin=0: remain in READ; wait counter increments, saturating at WAIT_LIMIT.
REQ-026 When the wait counter reaches WAIT_LIMIT, starveErr SHALL be set at that edge and held until reset; the read keeps waiting and no request is aborted.
REQ-027 memReadFin while not in READ SHALL be ignored.
REQ-028 In WRITE: memWriteEn=1 for exactly one cycle with memWriteAddr/memWriteData = latched values; respData loads the latched write data; next state RESP.
REQ-029 memWriteEn SHALL be 0 in every state other than WRITE; memReadEn SHALL be 0 in every state other than READ.
REQ-030 In RESP: respValid=1 and respData stable; when respReady=1, next state IDLE; otherwise hold.
REQ-031 No overlap of requests: reqValid is not accepted in RESP, so there is one bubble cycle between back-to-back requests.
REQ-032 Latency: read with immediate grant gives respValid 2 cycles after the accept edge; a write gives respValid 2 cycles after the accept edge; each grant-stall cycle adds 1 cycle.
REQ-033 memReadAddr/memWriteAddr/memWriteData SHALL reflect the latched request register at all times; they are don't-care when the corresponding enable is 0.

Reset
REQ-034 When rst=0, asynchronously: state=IDLE, respValid=0, respData=0, memReadEn=0, memWriteEn=0, wait counter=0, starveErr=0, latched address/data=0.
REQ-035 Reset asserted mid-READ or mid-WRITE SHALL abort the operation with no further memWriteEn pulse; the first request after rst returns to 1 is handled normally.

Verification
REQ-036 Write reqAddr=0x10, reqWdata=0xDEADBEEF -> one-cycle memWriteEn with addr 0x10; respValid with respData=0xDEADBEEF 2 cycles after accept.
REQ-037 Read addr 0x10, memReadFin=1 at first READ cycle, memReadData=0xDEADBEEF -> respData=0xDEADBEEF, respValid 2 cycles after accept.
REQ-038 Read with memReadFin held 0 for 5 cycles, then 1 -> memReadEn/memReadAddr stable for 6 cycles, respValid 7 cycles after accept, starveErr=0.
REQ-039 Read with memReadFin held 0 for 20 cycles, WAIT_LIMIT=15 -> starveErr=1 after the 15th stall cycle, stays 1 after completion until rst.
REQ-040 respReady held 0 for 4 cycles in RESP while reqValid=1 -> reqReady=0 and respData unchanged; accept occurs the cycle after respReady=1.
REQ-041 rst pulsed low during READ -> all outputs at reset values immediately, no memWriteEn; a subsequent write completes normally.

Source files
------------

// File: rtl/mem_port_master_if.sv
// rtl/mem_port_master_if.sv - client request/response and storage port bundle for mem_port_master
interface mem_port_master_if #(
   parameter int ADDR_SIZE = 28,
   parameter int ROW_WIDTH = 32
);
   // client request channel
   logic                 reqValid;
   logic                 reqReady;
   logic                 reqWrite;
   logic [ADDR_SIZE-1:0] reqAddr;
   logic [ROW_WIDTH-1:0] reqWdata;

   // client response channel
   logic                 respValid;
   logic                 respReady;
   logic [ROW_WIDTH-1:0] respData;

   // storage read port
   logic [ADDR_SIZE-1:0] memReadAddr;
   logic                 memReadEn;
   logic                 memReadFin;
   logic [ROW_WIDTH-1:0] memReadData;

   // storage write port
   logic [ADDR_SIZE-1:0] memWriteAddr;
   logic [ROW_WIDTH-1:0] memWriteData;
   logic                 memWriteEn;

   // sticky read-starvation flag
   logic                 starveErr;

   modport master (
      input  reqValid, reqWrite, reqAddr, reqWdata, respReady, memReadFin, memReadData,
      output reqReady, respValid, respData, memReadAddr, memReadEn,
             memWriteAddr, memWriteData, memWriteEn, starveErr
   );

   modport slave (
      output reqValid, reqWrite, reqAddr, reqWdata, respReady, memReadFin, memReadData,
      input  reqReady, respValid, respData, memReadAddr, memReadEn,
             memWriteAddr, memWriteData, memWriteEn, starveErr
   );
endinterface

// File: rtl/mem_port_master.sv
// rtl/mem_port_master.sv - single-outstanding request master bridging a client to a storage row port
module mem_port_master #(
   parameter int ADDR_SIZE  = 28,
   parameter int ROW_WIDTH  = 32,
   parameter int WAIT_LIMIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_master_if.master bus
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   localparam logic [3:0] LIMIT = 4'(WAIT_LIMIT);

   state_t               state;
   state_t               state_nxt;
   logic [ADDR_SIZE-1:0] addr_q;
   logic [ROW_WIDTH-1:0] wdata_q;
   logic [ROW_WIDTH-1:0] resp_q;
   logic [3:0]           wait_cnt;
   logic                 starve_q;
   logic                 accept;

   // The direction of the accepted request lives in the state itself (READ vs WRITE),
   // so no separate write-flag register is kept.
   assign accept = (state == IDLE) && bus.reqValid;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state decision
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.reqValid)   state_nxt = bus.reqWrite ? WRITE : READ;
         READ:    if (bus.memReadFin) state_nxt = RESP;
         WRITE:                       state_nxt = RESP;
         RESP:    if (bus.respReady)  state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
   end

   // Handshake and enable outputs decoded from state
   always_comb begin
      bus.reqReady   = 1'b0;
      bus.respValid  = 1'b0;
      bus.memReadEn  = 1'b0;
      bus.memWriteEn = 1'b0;
      unique case (state)
         IDLE:    bus.reqReady   = 1'b1;
         READ:    bus.memReadEn  = 1'b1;
         WRITE:   bus.memWriteEn = 1'b1;
         RESP:    bus.respValid  = 1'b1;
         default: bus.reqReady   = 1'b0;
      endcase
   end

   // Request latch, response register, grant-wait counter and sticky starvation flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         resp_q   <= '0;
         wait_cnt <= '0;
         starve_q <= 1'b0;
      end else begin
         if (accept) begin
            addr_q   <= bus.reqAddr;
            wdata_q  <= bus.reqWdata;
            wait_cnt <= '0;
         end
         if (state == READ) begin
            if (bus.memReadFin) begin
               resp_q <= bus.memReadData;
            end else if (wait_cnt != LIMIT) begin
               // saturate at the limit; the flag fires on the edge the limit is reached
               wait_cnt <= wait_cnt + 4'd1;
               if (wait_cnt + 4'd1 == LIMIT) starve_q <= 1'b1;
            end
         end
         if (state == WRITE) resp_q <= wdata_q;
      end
   end

   assign bus.respData     = resp_q;
   assign bus.memReadAddr  = addr_q;
   assign bus.memWriteAddr = addr_q;
   assign bus.memWriteData = wdata_q;
   assign bus.starveErr    = starve_q;
endmodule

// File: tb/tb_mem_port_master.sv
// tb/tb_mem_port_master.sv - randomized self-checking bench for mem_port_master against a storage model
module tb_mem_port_master;
   localparam int AW = 28;
   localparam int DW = 32;
   localparam int WL = 15;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic [DW-1:0] model_mem [logic [AW-1:0]];
   bit            exp_starve = 1'b0;

   always #5 clk = ~clk;

   mem_port_master_if #(.ADDR_SIZE(AW), .ROW_WIDTH(DW)) bus ();

   mem_port_master #(.ADDR_SIZE(AW), .ROW_WIDTH(DW), .WAIT_LIMIT(WL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // storage contents: last written value, or a fixed address-derived pattern if never written
   function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
      if (model_mem.exists(a)) return model_mem[a];
      return 32'hA5A5_0000 ^ DW'(a);
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!bus.reqReady && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("req_ready", bus.reqReady, 1);
   endtask

   // one complete transaction: stalls = grant-stall cycles, hold = cycles respReady kept low
   task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int stalls, input int hold);
      int            lat, rd_cyc, wr_cyc;
      bit            addr_ok;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd, exp_data;
      @(negedge clk);
      bus.reqValid = 1'b1;
      bus.reqWrite = wr;
      bus.reqAddr  = a;
      bus.reqWdata = d;
      bus.respReady = 1'b0;
      wait_ready();
      exp_data = wr ? d : model_rd(a);
      @(negedge clk);
      bus.reqValid = 1'b0;
      bus.reqAddr  = ~a;
      bus.reqWdata = ~d;
      lat = 1; rd_cyc = 0; wr_cyc = 0; addr_ok = 1'b1; wa = '0; wd = '0;
      while (!bus.respValid && lat < 100) begin
         if (bus.memReadEn) begin
            rd_cyc++;
            if (bus.memReadAddr !== a) addr_ok = 1'b0;
            if (rd_cyc == WL)     check("starve_before_limit", bus.starveErr, exp_starve);
            if (rd_cyc == WL + 1) check("starve_at_limit", bus.starveErr, 1);
            bus.memReadFin  = (rd_cyc == stalls + 1);
            bus.memReadData = model_rd(bus.memReadAddr);
         end else begin
            bus.memReadFin  = 1'($urandom_range(0, 1));
            bus.memReadData = $urandom;
         end
         if (bus.memWriteEn) begin
            wr_cyc++;
            wa = bus.memWriteAddr;
            wd = bus.memWriteData;
         end
         @(negedge clk);
         lat++;
      end
      check("resp_latency", lat, wr ? 2 : 2 + stalls);
      check("read_cycles", rd_cyc, wr ? 0 : stalls + 1);
      check("write_pulses", wr_cyc, wr ? 1 : 0);
      check("read_addr_stable", addr_ok, 1);
      check("resp_data", bus.respData, exp_data);
      if (wr) begin
         check("write_addr", wa, a);
         check("write_data", wd, d);
         model_mem[a] = d;
      end
      if (!wr && stalls >= WL) exp_starve = 1'b1;
      check("starve_flag", bus.starveErr, exp_starve);
      for (int i = 0; i < hold; i++) begin
         bus.reqValid = 1'b1;
         bus.reqWrite = 1'b1;
         bus.memReadFin  = 1'($urandom_range(0, 1));
         bus.memReadData = $urandom;
         @(negedge clk);
         check("hold_req_ready", bus.reqReady, 0);
         check("hold_resp_valid", bus.respValid, 1);
         check("hold_resp_data", bus.respData, exp_data);
      end
      bus.respReady = 1'b1;
      @(negedge clk);
      bus.respReady  = 1'b0;
      bus.reqValid   = 1'b0;
      bus.memReadFin = 1'b0;
      check("idle_req_ready", bus.reqReady, 1);
      check("idle_resp_valid", bus.respValid, 0);
      check("idle_no_write", bus.memWriteEn, 0);
      check("idle_no_read", bus.memReadEn, 0);
   endtask

   // accept a request, then pull reset while it is in flight
   task automatic reset_mid(input bit wr);
      @(negedge clk);
      bus.reqValid   = 1'b1;
      bus.reqWrite   = wr;
      bus.reqAddr    = AW'($urandom_range(0, 15));
      bus.reqWdata   = $urandom;
      bus.memReadFin = 1'b0;
      wait_ready();
      @(negedge clk);
      bus.reqValid = 1'b0;
      if (!wr) begin
         repeat (2) begin
            check("rst_pre_read_en", bus.memReadEn, 1);
            @(negedge clk);
         end
      end else begin
         check("rst_pre_write_en", bus.memWriteEn, 1);
      end
      rst = 1'b0;
      #1;
      check("rst_req_ready", bus.reqReady, 1);
      check("rst_resp_valid", bus.respValid, 0);
      check("rst_resp_data", bus.respData, 0);
      check("rst_read_en", bus.memReadEn, 0);
      check("rst_write_en", bus.memWriteEn, 0);
      check("rst_starve", bus.starveErr, 0);
      check("rst_read_addr", bus.memReadAddr, 0);
      @(negedge clk);
      check("rst_hold_write_en", bus.memWriteEn, 0);
      rst = 1'b1;
      exp_starve = 1'b0;
      @(negedge clk);
      check("post_rst_write_en", bus.memWriteEn, 0);
      check("post_rst_req_ready", bus.reqReady, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.reqValid    = 1'b0;
      bus.reqWrite    = 1'b0;
      bus.reqAddr     = '0;
      bus.reqWdata    = '0;
      bus.respReady   = 1'b0;
      bus.memReadFin  = 1'b0;
      bus.memReadData = '0;
      rst = 1'b1;
      #3 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_req_ready", bus.reqReady, 1);
      check("reset_resp_valid", bus.respValid, 0);
      check("reset_resp_data", bus.respData, 0);
      check("reset_read_en", bus.memReadEn, 0);
      check("reset_write_en", bus.memWriteEn, 0);
      check("reset_starve", bus.starveErr, 0);
      rst = 1'b1;

      do_req(1'b1, AW'(32'h10), 32'hDEAD_BEEF, 0, 0);
      do_req(1'b0, AW'(32'h10), '0, 0, 0);
      do_req(1'b0, AW'(32'h10), '0, 5, 4);
      do_req(1'b0, AW'(32'h3), '0, WL - 1, 0);
      do_req(1'b0, AW'(32'h4), '0, WL, 0);
      do_req(1'b0, AW'(32'h5), '0, 20, 2);
      do_req(1'b1, AW'(32'h6), 32'h1234_5678, 0, 1);

      reset_mid(1'b0);
      do_req(1'b1, AW'(32'h7), 32'hCAFE_F00D, 0, 0);
      do_req(1'b0, AW'(32'h7), '0, 1, 0);

      for (int t = 0; t < 40; t++) begin
         do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                $urandom_range(0, 6), $urandom_range(0, 3));
      end

      reset_mid(1'b1);
      do_req(1'b1, AW'(32'h9), 32'h0BAD_CAFE, 0, 0);
      do_req(1'b0, AW'(32'h9), '0, 2, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
